memory_port_arbiter: RTL and testbench

Shares one single-ported memory bus between the instruction-fetch stage and the memory-access (load/store) stage of the five-stage pipeline. Grants one requester at a time, latches its address, write data and direction, then holds the bus until the memory acknowledges. Raises `stall_o` into the pipeline stall chain while any request is outstanding, so the decode stage's `stall_i` freezes operand and instruction latches during memory wait states.

---
 rtl/memory_port_arbiter_pkg.sv | 26 ++
 rtl/memory_port_arbiter_if.sv | 56 +++++
 rtl/memory_port_arbiter_mem_wait_counter.sv | 34 +++
 rtl/memory_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : memory_port_arbiter_pkg
// Brief   : Shared encodings for the fetch / load-store memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package memory_port_arbiter_pkg;

    localparam int c_state_w = 2;

    localparam logic [c_state_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_state_w-1:0] c_st_fetch = 2'd1;
    localparam logic [c_state_w-1:0] c_st_data  = 2'd2;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_owner_e;

    localparam int c_wait_cnt_w = 8;

    // Every bit of the word returned to the owner on a bus timeout.
    localparam logic c_timeout_data_bit = 1'b0;

endpackage : memory_port_arbiter_pkg
`default_nettype wire

// File: rtl/memory_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : memory_port_arbiter_if
// Brief   : Fetch, load/store and memory-bus signals of the port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface memory_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ifetch_req_i;
    logic [ADDR_WIDTH-1:0] ifetch_addr_i;
    logic [DATA_WIDTH-1:0] ifetch_data_o;
    logic                  ifetch_ack_o;

    logic                  data_req_i;
    logic                  data_write_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic [DATA_WIDTH-1:0] data_rdata_o;
    logic                  data_ack_o;

    logic                  mem_req_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;

    logic                  stall_o;
    logic                  bus_error_o;

    // Arbiter view.
    modport slave (
        input  ifetch_req_i, ifetch_addr_i,
        input  data_req_i, data_write_i, data_addr_i, data_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output ifetch_data_o, ifetch_ack_o,
        output data_rdata_o, data_ack_o,
        output mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o,
        output stall_o, bus_error_o
    );

    // Pipeline-plus-memory environment view.
    modport master (
        output ifetch_req_i, ifetch_addr_i,
        output data_req_i, data_write_i, data_addr_i, data_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  ifetch_data_o, ifetch_ack_o,
        input  data_rdata_o, data_ack_o,
        input  mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o,
        input  stall_o, bus_error_o
    );

endinterface : memory_port_arbiter_if
`default_nettype wire

// File: rtl/memory_port_arbiter_mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_counter
// Brief   : Saturating wait-state counter with synchronous clear and a
//           terminal-count flag; used only when MEM_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
    parameter int CNT_WIDTH = 8,
    parameter int TERMINAL  = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_terminal = (r_count == CNT_WIDTH'(TERMINAL));

endmodule : mem_wait_counter
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : memory_port_arbiter
// Brief   : Fair two-way arbiter sharing one memory bus between instruction
//           fetch and load/store; optional wait-state timeout under the
//           MEM_TIMEOUT_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    memory_port_arbiter_if.slave bus
);

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_state_next;
    grant_owner_e          r_last_grant;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_write;

    logic                  w_busy;
    logic                  w_grant;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_data_wins;

    logic                  w_mem_req;
    logic                  w_ifetch_ack;
    logic                  w_data_ack;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_busy  = (r_state != c_st_idle);
    assign w_grant = (r_state == c_st_idle) && (w_state_next != c_st_idle);
    assign w_done  = w_busy && (bus.mem_ack_i || w_timeout);

    // On a tie the requester that was not served last gets the bus.
    assign w_data_wins = bus.data_req_i &&
                         (!bus.ifetch_req_i || (r_last_grant == GRANT_FETCH));

`ifdef MEM_TIMEOUT_EN
    logic w_cnt_enable;
    logic w_cnt_terminal;

    assign w_cnt_enable = w_busy && !bus.mem_ack_i;

    mem_wait_counter #(
        .CNT_WIDTH (c_wait_cnt_w),
        .TERMINAL  (TIMEOUT_CYCLES)
    ) u_mem_wait_counter (
        .clk        (clock_i),
        .rst        (reset_i),
        .i_clear    (w_grant),
        .i_enable   (w_cnt_enable),
        .o_terminal (w_cnt_terminal)
    );

    // A real acknowledge in the terminal cycle takes precedence.
    assign w_timeout = w_busy && w_cnt_terminal && !bus.mem_ack_i;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_data_wins) begin
                    w_state_next = c_st_data;
                end else if (bus.ifetch_req_i) begin
                    w_state_next = c_st_fetch;
                end
            end
            c_st_fetch, c_st_data: begin
                if (w_done) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus fields are captured only on the grant edge and held until the
    // next grant, whatever the requesters do in between.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_write  <= 1'b0;
            r_last_grant <= GRANT_FETCH;
        end else begin
            if (w_grant) begin
                if (w_state_next == c_st_data) begin
                    r_mem_addr  <= bus.data_addr_i;
                    r_mem_wdata <= bus.data_wdata_i;
                    r_mem_write <= bus.data_write_i;
                end else begin
                    r_mem_addr  <= bus.ifetch_addr_i;
                    r_mem_write <= 1'b0;
                end
            end
            if (w_done) begin
                r_last_grant <= (r_state == c_st_data) ? GRANT_DATA : GRANT_FETCH;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_req    = w_busy;
        w_ifetch_ack = (r_state == c_st_fetch) && w_done;
        w_data_ack   = (r_state == c_st_data) && w_done;
        w_rdata      = bus.mem_rdata_i;
        if (w_timeout) begin
            w_rdata = {DATA_WIDTH{c_timeout_data_bit}};
        end
    end

    assign bus.mem_req_o     = w_mem_req;
    assign bus.mem_write_o   = r_mem_write;
    assign bus.mem_addr_o    = r_mem_addr;
    assign bus.mem_wdata_o   = r_mem_wdata;
    assign bus.ifetch_ack_o  = w_ifetch_ack;
    assign bus.data_ack_o    = w_data_ack;
    assign bus.ifetch_data_o = w_rdata;
    assign bus.data_rdata_o  = w_rdata;
    assign bus.bus_error_o   = w_timeout;
    assign bus.stall_o       = (bus.ifetch_req_i && !w_ifetch_ack) ||
                               (bus.data_req_i && !w_data_ack);

endmodule : memory_port_arbiter
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_port_arbiter
// Brief   : Self-checking bench: directed scenarios plus randomized traffic
//           against a transaction-level bus-ownership model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Memory responder configuration (written by the test tasks only).
    bit          resp_en   = 1'b0;
    bit          resp_rand = 1'b0;
    int          resp_wait = 0;
    logic [DW-1:0] resp_data = '0;

    int resp_cnt  = 0;
    int rand_wait = 0;

    memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Memory model: acks after a programmable number of wait cycles.
    always @(negedge clk) begin
        if (resp_en && (bus.mem_req_o === 1'b1) &&
            (resp_cnt >= (resp_rand ? rand_wait : resp_wait))) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = resp_rand ? DW'($urandom) : resp_data;
            resp_cnt        = 0;
            rand_wait       = $urandom_range(0, 3);
        end else begin
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = DW'($urandom);
            resp_cnt        = (resp_en && (bus.mem_req_o === 1'b1)) ? resp_cnt + 1 : 0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ifetch_req_i = 1'b0;
        bus.data_req_i   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h44;
        bus.data_req_i = 1'b0; bus.data_write_i = 1'b0;
        bus.data_addr_i = '0; bus.data_wdata_i = '0;
        @(negedge clk); #1;
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req_o); end
        checks++; if (bus.mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", bus.mem_write_o); end
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_o); end
        checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata_o); end
        checks++; if ({bus.ifetch_ack_o, bus.data_ack_o, bus.bus_error_o} !== 3'b000) begin errors++; $display("FAIL reset_acks got %b want 000", {bus.ifetch_ack_o, bus.data_ack_o, bus.bus_error_o}); end
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", bus.stall_o); end
        bus.ifetch_req_i = 1'b0; #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b want 0", bus.stall_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        bit got = 1'b0;
        int n = 0;
        resp_en = 1'b1; resp_rand = 1'b0; resp_wait = 2; resp_data = 32'h12345678;
        @(negedge clk);
        bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h100;
        #1;
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_pre_grant got %b want 0", bus.mem_req_o); end
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL fetch_stall_req got %b want 1", bus.stall_o); end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); #1; n++;
            checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h100 || bus.mem_write_o !== 1'b0) begin errors++; $display("FAIL fetch_bus got req=%b addr=%h wr=%b want 1/100/0", bus.mem_req_o, bus.mem_addr_o, bus.mem_write_o); end
            if (bus.ifetch_ack_o === 1'b1) begin
                got = 1'b1;
                checks++; if (bus.ifetch_data_o !== 32'h12345678) begin errors++; $display("FAIL fetch_data got %h want 12345678", bus.ifetch_data_o); end
                checks++; if (n != 3) begin errors++; $display("FAIL fetch_latency got %0d want 3", n); end
                checks++; if (bus.stall_o !== 1'b0 || bus.data_ack_o !== 1'b0) begin errors++; $display("FAIL fetch_ack_cycle got stall=%b dack=%b want 0/0", bus.stall_o, bus.data_ack_o); end
            end else begin
                checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL fetch_stall_wait got %b want 1", bus.stall_o); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL fetch_ack_timeout got none want ack"); end
        @(negedge clk);
        bus.ifetch_req_i = 1'b0; #1;
        checks++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL fetch_release got req=%b stall=%b want 0/0", bus.mem_req_o, bus.stall_o); end
    endtask

    task automatic test_tie_store_first();
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_wait = 0; resp_data = 32'h0BADBEEF;
        @(negedge clk);
        bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h300;
        bus.data_req_i = 1'b1; bus.data_write_i = 1'b1;
        bus.data_addr_i = 32'h200; bus.data_wdata_i = 32'hCAFEF00D;
        @(negedge clk); #1;
        checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h200 || bus.mem_write_o !== 1'b1) begin errors++; $display("FAIL tie_data_grant got req=%b addr=%h wr=%b want 1/200/1", bus.mem_req_o, bus.mem_addr_o, bus.mem_write_o); end
        checks++; if (bus.mem_wdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL tie_wdata got %h want cafef00d", bus.mem_wdata_o); end
        checks++; if (bus.data_ack_o !== 1'b1 || bus.ifetch_ack_o !== 1'b0 || bus.stall_o !== 1'b1) begin errors++; $display("FAIL tie_acks got dack=%b fack=%b stall=%b want 1/0/1", bus.data_ack_o, bus.ifetch_ack_o, bus.stall_o); end
        @(negedge clk);
        bus.data_req_i = 1'b0; bus.data_addr_i = 32'h999; #1;
        checks++; if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h200) begin errors++; $display("FAIL tie_idle_gap got req=%b addr=%h want 0/200", bus.mem_req_o, bus.mem_addr_o); end
        @(negedge clk); #1;
        checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h300 || bus.mem_write_o !== 1'b0 || bus.ifetch_ack_o !== 1'b1) begin errors++; $display("FAIL tie_fetch_second got req=%b addr=%h wr=%b fack=%b want 1/300/0/1", bus.mem_req_o, bus.mem_addr_o, bus.mem_write_o, bus.ifetch_ack_o); end
        @(negedge clk);
        bus.ifetch_req_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] f_addr = 32'h1000;
        logic [31:0] d_addr = 32'h2000;
        bit f_next = 1'b0;
        bit d_next = 1'b0;
        logic exp_req, exp_data;
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_wait = 0;
        @(negedge clk);
        bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = f_addr;
        bus.data_req_i = 1'b1; bus.data_write_i = 1'b0; bus.data_addr_i = d_addr;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (f_next) begin f_addr = f_addr + 32'd4; bus.ifetch_addr_i = f_addr; f_next = 1'b0; end
            if (d_next) begin d_addr = d_addr + 32'd4; bus.data_addr_i = d_addr; d_next = 1'b0; end
            #1;
            exp_req = (c % 2 == 0);
            checks++; if (bus.mem_req_o !== exp_req) begin errors++; $display("FAIL b2b_req cycle %0d got %b want %b", c, bus.mem_req_o, exp_req); end
            if (exp_req) begin
                exp_data = ((c / 2) % 2 == 0);
                checks++; if (bus.data_ack_o !== exp_data || bus.ifetch_ack_o !== !exp_data) begin errors++; $display("FAIL b2b_owner cycle %0d got dack=%b fack=%b want data=%b", c, bus.data_ack_o, bus.ifetch_ack_o, exp_data); end
                checks++; if (bus.mem_addr_o !== (exp_data ? d_addr : f_addr)) begin errors++; $display("FAIL b2b_addr cycle %0d got %h want %h", c, bus.mem_addr_o, exp_data ? d_addr : f_addr); end
                if (exp_data) d_next = 1'b1; else f_next = 1'b1;
            end
        end
        @(negedge clk);
        bus.ifetch_req_i = 1'b0; bus.data_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_wait = 100;
        @(negedge clk);
        bus.data_req_i = 1'b1; bus.data_write_i = 1'b0; bus.data_addr_i = 32'h400;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.data_addr_i = 32'h404; #1;
            checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h400 || bus.data_ack_o !== 1'b0) begin errors++; $display("FAIL rst_mid_wait got req=%b addr=%h dack=%b want 1/400/0", bus.mem_req_o, bus.mem_addr_o, bus.data_ack_o); end
        end
        @(negedge clk);
        rst = 1'b1; resp_wait = 0; #1;
        checks++; if (bus.mem_req_o !== 1'b0 || bus.data_ack_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_mid_drop got req=%b dack=%b addr=%h want 0/0/0", bus.mem_req_o, bus.data_ack_o, bus.mem_addr_o); end
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL rst_mid_stall got %b want 1", bus.stall_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h404 || bus.data_ack_o !== 1'b1) begin errors++; $display("FAIL rst_mid_regrant got req=%b addr=%h dack=%b want 1/404/1", bus.mem_req_o, bus.mem_addr_o, bus.data_ack_o); end
        @(negedge clk);
        bus.data_req_i = 1'b0;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_wait = 200; resp_data = 32'hA5A55A5A;
        @(negedge clk);
        bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h500;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk); #1;
            if (n < 5) begin
                checks++; if (bus.mem_req_o !== 1'b1 || bus.ifetch_ack_o !== 1'b0 || bus.bus_error_o !== 1'b0) begin errors++; $display("FAIL to_wait cycle %0d got req=%b fack=%b err=%b want 1/0/0", n, bus.mem_req_o, bus.ifetch_ack_o, bus.bus_error_o); end
            end else begin
                checks++; if (bus.ifetch_ack_o !== 1'b1 || bus.bus_error_o !== 1'b1 || bus.ifetch_data_o !== 32'h0) begin errors++; $display("FAIL to_fire got fack=%b err=%b data=%h want 1/1/0", bus.ifetch_ack_o, bus.bus_error_o, bus.ifetch_data_o); end
            end
        end
        @(negedge clk);
        bus.ifetch_req_i = 1'b0; resp_wait = 4; #1;
        checks++; if (bus.mem_req_o !== 1'b0 || bus.bus_error_o !== 1'b0) begin errors++; $display("FAIL to_release got req=%b err=%b want 0/0", bus.mem_req_o, bus.bus_error_o); end
        @(negedge clk);
        bus.ifetch_req_i = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk); #1;
            if (n == 5) begin
                checks++; if (bus.ifetch_ack_o !== 1'b1 || bus.bus_error_o !== 1'b0 || bus.ifetch_data_o !== 32'hA5A55A5A) begin errors++; $display("FAIL to_ack_wins got fack=%b err=%b data=%h want 1/0/a5a55a5a", bus.ifetch_ack_o, bus.bus_error_o, bus.ifetch_data_o); end
            end
        end
        @(negedge clk);
        bus.ifetch_req_i = 1'b0;
    endtask
`endif

    // Randomized traffic against a bus-ownership model: owner 0 = free,
    // 1 = fetch, 2 = load/store; ties go to whoever was not served last.
    task automatic test_random_traffic();
        bit f_req = 1'b0, d_req = 1'b0, f_drop = 1'b0, d_drop = 1'b0;
        logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
        bit d_write = 1'b0;
        int owner = 0, last = 1;
        logic [31:0] m_addr = '0, m_wdata = '0;
        bit m_write = 1'b0;
        logic exp_fack, exp_dack, exp_stall;
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (f_drop) begin f_req = 1'b0; f_drop = 1'b0; end
            else if (!f_req && $urandom_range(0, 2) == 0) begin f_req = 1'b1; f_addr = $urandom; end
            if (d_drop) begin d_req = 1'b0; d_drop = 1'b0; end
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_write = 1'($urandom);
            end
            bus.ifetch_req_i = f_req; bus.ifetch_addr_i = f_addr;
            bus.data_req_i = d_req; bus.data_addr_i = d_addr;
            bus.data_wdata_i = d_wdata; bus.data_write_i = d_write;
            #1;
            exp_fack  = (owner == 1) && bus.mem_ack_i;
            exp_dack  = (owner == 2) && bus.mem_ack_i;
            exp_stall = (f_req && !exp_fack) || (d_req && !exp_dack);
            checks++; if (bus.mem_req_o !== (owner != 0)) begin errors++; $display("FAIL rnd_req cycle %0d got %b want %b", cyc, bus.mem_req_o, owner != 0); end
            if (owner != 0) begin
                checks++; if (bus.mem_addr_o !== m_addr || bus.mem_write_o !== m_write) begin errors++; $display("FAIL rnd_fields cycle %0d got addr=%h wr=%b want %h/%b", cyc, bus.mem_addr_o, bus.mem_write_o, m_addr, m_write); end
                if (m_write) begin
                    checks++; if (bus.mem_wdata_o !== m_wdata) begin errors++; $display("FAIL rnd_wdata cycle %0d got %h want %h", cyc, bus.mem_wdata_o, m_wdata); end
                end
            end
            checks++; if (bus.ifetch_ack_o !== exp_fack || bus.data_ack_o !== exp_dack) begin errors++; $display("FAIL rnd_acks cycle %0d got f=%b d=%b want f=%b d=%b", cyc, bus.ifetch_ack_o, bus.data_ack_o, exp_fack, exp_dack); end
            if (exp_fack) begin
                checks++; if (bus.ifetch_data_o !== bus.mem_rdata_i) begin errors++; $display("FAIL rnd_fdata cycle %0d got %h want %h", cyc, bus.ifetch_data_o, bus.mem_rdata_i); end
            end
            if (exp_dack) begin
                checks++; if (bus.data_rdata_o !== bus.mem_rdata_i) begin errors++; $display("FAIL rnd_ddata cycle %0d got %h want %h", cyc, bus.data_rdata_o, bus.mem_rdata_i); end
            end
            checks++; if (bus.stall_o !== exp_stall || bus.bus_error_o !== 1'b0) begin errors++; $display("FAIL rnd_stall cycle %0d got stall=%b err=%b want %b/0", cyc, bus.stall_o, bus.bus_error_o, exp_stall); end
            // Advance the model to the next cycle.
            if (owner != 0) begin
                if (bus.mem_ack_i === 1'b1) begin
                    if (owner == 1) f_drop = 1'b1; else d_drop = 1'b1;
                    last  = owner;
                    owner = 0;
                end
            end else if (f_req || d_req) begin
                if (f_req && d_req) owner = (last == 1) ? 2 : 1;
                else                owner = f_req ? 1 : 2;
                if (owner == 1) begin m_addr = f_addr; m_write = 1'b0; end
                else begin m_addr = d_addr; m_write = d_write; m_wdata = d_wdata; end
            end
        end
        @(negedge clk);
        bus.ifetch_req_i = 1'b0; bus.data_req_i = 1'b0;
        resp_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_tie_store_first();
        test_back_to_back();
        test_reset_mid_data();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_memory_port_arbiter
`default_nettype wire
